// File: rtl/pipe_alu_pkg.sv
// rtl/pipe_alu_pkg.sv - shared command codes, flag bit positions and state type for pipe_alu
package pipe_alu_pkg;

  localparam logic [3:0] CMD_ADD    = 4'd0;
  localparam logic [3:0] CMD_SUB    = 4'd1;
  localparam logic [3:0] CMD_AND    = 4'd2;
  localparam logic [3:0] CMD_OR     = 4'd3;
  localparam logic [3:0] CMD_XOR    = 4'd4;
  localparam logic [3:0] CMD_NOR    = 4'd5;
  localparam logic [3:0] CMD_NOT    = 4'd6;
  localparam logic [3:0] CMD_SLL    = 4'd7;
  localparam logic [3:0] CMD_SRL    = 4'd8;
  localparam logic [3:0] CMD_SRA    = 4'd9;
  localparam logic [3:0] CMD_INC    = 4'd10;
  localparam logic [3:0] CMD_DEC    = 4'd11;
  localparam logic [3:0] CMD_POPCNT = 4'd12;
  localparam logic [3:0] CMD_SLT    = 4'd13;
  localparam logic [3:0] CMD_MUL    = 4'd14;
  localparam logic [3:0] CMD_RSVD   = 4'd15;

  // flags = {neg, zero, carry, ovf}
  localparam int FLAG_NEG   = 3;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_alu_mul.sv
// rtl/pipe_alu_mul.sv - unsigned shift-add multiplier, one multiplier bit per cycle
module pipe_alu_mul #(
  parameter int N = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N);

  logic [CW-1:0]  cnt;
  logic           run;
  logic [2*N-1:0] mcand;
  logic [2*N-1:0] acc;
  logic [N-1:0]   mplier;

  // load operands on start, then add the shifted multiplicand for each set multiplier bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      run    <= 1'b0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
    end else if (start) begin
      cnt    <= '0;
      run    <= 1'b1;
      mcand  <= {{N{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
    end else if (run) begin
      if (cnt != CNT_LAST) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= {mcand[2*N-2:0], 1'b0};
        mplier <= {1'b0, mplier[N-1:1]};
        cnt    <= cnt + 1'b1;
      end else begin
        // done is a single-cycle pulse; the parent captures the product in that cycle
        run <= 1'b0;
      end
    end
  end

  assign done    = run && (cnt == CNT_LAST);
  assign product = acc;

endmodule

// File: rtl/pipe_alu.sv
// rtl/pipe_alu.sv - handshaked ALU with registered results; MUL present only with PIPE_ALU_MUL_EN
module pipe_alu
  import pipe_alu_pkg::*;
#(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   CMD,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Z,
  output logic [3:0]   flags,
  output logic         err
);

  localparam logic [N-1:0] N_W = N[N-1:0];

  state_t state, state_nxt;

  logic         accept;
  logic         is_mul;
  logic         accept_single;
  logic         mul_done;
  logic [N-1:0] shamt;

  logic [N-1:0] alu_z;
  logic         alu_c;
  logic         alu_v;
  logic         alu_err;
  logic [N:0]   sum;
  logic [N:0]   diff;
  logic [N-1:0] pc;

  assign accept        = (state == ST_IDLE) && in_valid;
  assign accept_single = accept && !is_mul;
  assign shamt         = B % N_W;

`ifdef PIPE_ALU_MUL_EN
  logic [2*N-1:0] product;

  assign is_mul = (CMD == CMD_MUL);

  pipe_alu_mul #(.N(N)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (A),
    .b       (B),
    .done    (mul_done),
    .product (product)
  );
`else
  // without the multiplier CMD 14 falls into the reserved path below
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = is_mul ? ST_BUSY : ST_DONE;
        end
      end
      ST_BUSY: begin
        if (mul_done) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // single-cycle datapath computed from the live inputs, sampled only on accept
  always_comb begin
    alu_z   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    sum     = '0;
    diff    = '0;
    pc      = '0;
    case (CMD)
      CMD_ADD: begin
        sum   = {1'b0, A} + {1'b0, B};
        alu_z = sum[N-1:0];
        alu_c = sum[N];
        alu_v = (A[N-1] == B[N-1]) && (sum[N-1] != A[N-1]);
      end
      CMD_SUB: begin
        diff  = {1'b0, A} - {1'b0, B};
        alu_z = diff[N-1:0];
        alu_c = diff[N];
        alu_v = (A[N-1] != B[N-1]) && (diff[N-1] != A[N-1]);
      end
      CMD_AND: alu_z = A & B;
      CMD_OR:  alu_z = A | B;
      CMD_XOR: alu_z = A ^ B;
      CMD_NOR: alu_z = ~(A | B);
      CMD_NOT: alu_z = ~A;
      CMD_SLL: alu_z = A << shamt;
      CMD_SRL: alu_z = A >> shamt;
      CMD_SRA: alu_z = $signed(A) >>> shamt;
      CMD_INC: begin
        sum   = {1'b0, A} + {{N{1'b0}}, 1'b1};
        alu_z = sum[N-1:0];
        alu_c = sum[N];
        alu_v = !A[N-1] && sum[N-1];
      end
      CMD_DEC: begin
        diff  = {1'b0, A} - {{N{1'b0}}, 1'b1};
        alu_z = diff[N-1:0];
        alu_c = diff[N];
        alu_v = A[N-1] && !diff[N-1];
      end
      CMD_POPCNT: begin
        for (int i = 0; i < N; i++) begin
          pc = pc + {{(N-1){1'b0}}, A[i]};
        end
        alu_z = pc;
      end
      CMD_SLT: alu_z = {{(N-1){1'b0}}, ($signed(A) < $signed(B))};
      default: begin
        // reserved code, or MUL when the multiplier is not built
        alu_z   = '0;
        alu_err = 1'b1;
      end
    endcase
  end

  // result registers: loaded on a single-cycle accept or multiplier completion, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Z     <= '0;
      flags <= '0;
      err   <= 1'b0;
    end else if (accept_single) begin
      Z                 <= alu_z;
      flags[FLAG_NEG]   <= alu_z[N-1];
      flags[FLAG_ZERO]  <= (alu_z == '0);
      flags[FLAG_CARRY] <= alu_c;
      flags[FLAG_OVF]   <= alu_v;
      err               <= alu_err;
    end
`ifdef PIPE_ALU_MUL_EN
    else if ((state == ST_BUSY) && mul_done) begin
      Z                 <= product[N-1:0];
      flags[FLAG_NEG]   <= product[N-1];
      flags[FLAG_ZERO]  <= (product[N-1:0] == '0);
      flags[FLAG_CARRY] <= (product[2*N-1:N] != '0);
      flags[FLAG_OVF]   <= 1'b0;
      err               <= 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_pipe_alu.sv
// tb/tb_pipe_alu.sv - randomized self-checking bench for pipe_alu against an arithmetic reference model
module tb_pipe_alu;

  localparam int N    = 6;
  localparam int MASK = (1 << N) - 1;
  localparam int HALF = 1 << (N - 1);

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [3:0]   CMD;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Z;
  logic [3:0]   flags;
  logic         err;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_alu #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .CMD       (CMD),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Z         (Z),
    .flags     (flags),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= HALF) ? v - (1 << N) : v;
  endfunction

  function automatic bit out_of_range(input int s);
    return (s > HALF - 1) || (s < -HALF);
  endfunction

  // reference: expected Z, flags, err and accept-to-out_valid latency
  task automatic model(input int a, input int b, input int cmd,
                       output int z, output int fl, output int e, output int lat);
    int sa, sb, sh, r, c, v;
    sa = sx(a); sb = sx(b); sh = b % N;
    r = 0; c = 0; v = 0; e = 0; lat = 1;
    case (cmd)
      0:  begin r = a + b; c = r >> N; v = int'(out_of_range(sa + sb)); end
      1:  begin r = a - b; c = int'(a < b); v = int'(out_of_range(sa - sb)); end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = ~(a | b);
      6:  r = ~a;
      7:  r = a << sh;
      8:  r = a >> sh;
      9:  r = sa >>> sh;
      10: begin r = a + 1; c = r >> N; v = int'(out_of_range(sa + 1)); end
      11: begin r = a - 1; c = int'(a == 0); v = int'(out_of_range(sa - 1)); end
      12: r = $countones(a);
      13: r = int'(sa < sb);
`ifdef PIPE_ALU_MUL_EN
      14: begin r = a * b; c = int'((r >> N) != 0); lat = N + 1; end
`endif
      default: begin r = 0; e = 1; end
    endcase
    z  = r & MASK;
    fl = (((z >> (N - 1)) & 1) << 3) | (int'(z == 0) << 2) | (c << 1) | v;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_z"},         32'(Z),         32'd0);
    chk({tag, "_flags"},     32'(flags),     32'd0);
    chk({tag, "_err"},       32'(err),       32'd0);
  endtask

  // one transaction: offer, wait for result, hold with out_ready low, then release
  task automatic run_op(input int a, input int b, input int cmd, input int hold, input bit noise);
    int z, fl, e, lat, n;
    model(a, b, cmd, z, fl, e, lat);
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    A = a[N-1:0]; B = b[N-1:0]; CMD = cmd[3:0]; in_valid = 1'b1;
    out_ready = noise ? 1'($urandom) : 1'b0;
    @(posedge clk);
    @(negedge clk);
    // later offers with fresh operands must be ignored
    A = N'($urandom); B = N'($urandom); CMD = 4'($urandom);
    n = 1;
    while (out_valid !== 1'b1 && n < lat + 10) begin
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      if (noise) out_ready = 1'($urandom);
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    chk("latency", n, lat);
    chk("z", 32'(Z), z);
    chk("flags", 32'(flags), fl);
    chk("err", 32'(err), e);
    chk("in_ready_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_z", 32'(Z), z);
      chk("hold_flags", 32'(flags), fl);
      chk("hold_err", 32'(err), e);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  // start an op, assert reset after some cycles, confirm no result afterwards
  task automatic reset_mid(input int cmd, input int cycles);
    A = 6'd9; B = 6'd9; CMD = cmd[3:0]; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N + 4; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; CMD = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // directed: first offer right after reset release
    run_op(5, 3, 8, 0, 1'b0);
    run_op(31, 1, 0, 5, 1'b0);
    run_op(9, 9, 14, 2, 1'b1);
    run_op(63, 63, 14, 0, 1'b0);
    run_op(0, 0, 14, 0, 1'b0);
    run_op(12, 34, 15, 1, 1'b0);
    run_op(63, 1, 0, 0, 1'b0);
    run_op(0, 1, 1, 0, 1'b0);
    run_op(32, 1, 1, 0, 1'b0);
    run_op(31, 0, 10, 0, 1'b0);
    run_op(63, 0, 10, 0, 1'b0);
    run_op(32, 0, 11, 0, 1'b0);
    run_op(0, 0, 11, 0, 1'b0);
    run_op(32, 5, 9, 0, 1'b0);
    run_op(33, 7, 7, 0, 1'b0);
    run_op(33, 6, 8, 0, 1'b0);
    run_op(63, 0, 12, 0, 1'b0);
    run_op(62, 1, 13, 0, 1'b0);

    // reset during a multi-cycle op and during a held result
    reset_mid(14, 2);
    run_op(7, 11, 14, 0, 1'b0);
    reset_mid(0, 1);
    run_op(21, 42, 4, 0, 1'b0);

    // randomized traffic with random hold times and out_ready noise
    for (int k = 0; k < 150; k++) begin
      run_op(int'($urandom_range(MASK)), int'($urandom_range(MASK)),
             int'($urandom_range(15)), int'($urandom_range(5)), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_alu.md
PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 Parameter N, default 6: operand/result width in bits, legal range 4..32.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand/command offer.
REQ-005 in_ready  output  1  block can accept an offer.
REQ-006 A  input  N  operand A.
REQ-007 B  input  N  operand B.
REQ-008 CMD  input  4  operation code.
REQ-009 out_valid  output  1  Z and flags are valid.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 Z  output  N  result.
REQ-012 flags  output  4  {neg, zero, carry, ovf}.
REQ-013 err  output  1  illegal or disabled CMD; valid with out_valid.

Function
REQ-014 Offer accepted when in_valid && in_ready; A, B and CMD are captured on that edge and ignored afterwards.
REQ-015 States: IDLE (in_ready=1), BUSY (multi-cycle op running), DONE (out_valid=1); in_ready=0 outside IDLE.
REQ-016 Transitions: IDLE->DONE on accepting a single-cycle op; IDLE->BUSY on accepting MUL; BUSY->DONE when the MUL counter reaches N; DONE->IDLE on out_ready.
REQ-017 CMD map: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 NOT A, 7 SLL, 8 SRL, 9 SRA, 10 INC A, 11 DEC A, 12 POPCNT A, 13 SLT signed, 14 MUL, 15 reserved.
REQ-018 Shift amount is B mod N; SRA replicates A[N-1].
REQ-019 ADD/INC: carry = carry-out; SUB/DEC: carry = borrow; ovf = two's-complement signed overflow; carry=ovf=0 for all other ops.
REQ-020 neg = Z[N-1]; zero = (Z==0); both are computed for every op.
REQ-021 MUL is unsigned shift-add, one bit per cycle; Z = low N bits of the product; carry = 1 iff the high N bits are nonzero.
REQ-022 Latency from accept to out_valid: 1 cycle for single-cycle ops, N+1 cycles for MUL.
REQ-023 Z, flags and err hold stable while out_valid=1 and out_ready=0.
REQ-024 CMD 15 returns Z=0, err=1, flags={0,1,0,0}, with 1-cycle latency.
REQ-025 out_ready asserted in IDLE or BUSY is ignored; in_valid asserted in BUSY or DONE is not accepted.

Reset
REQ-026 When rst_n is low: state=IDLE, in_ready=1, out_valid=0, Z=0, flags=0, err=0, MUL counter=0.
REQ-027 Reset asserted during BUSY or DONE discards the operation; no result is produced for it after reset is released.
REQ-028 The first offer can be accepted on the first rising clk edge after rst_n is released.

Configuration
REQ-029 Macro PIPE_ALU_MUL_EN defined: MUL is implemented as specified in REQ-021/REQ-022.
REQ-030 Macro undefined: no multiplier logic; CMD 14 behaves as CMD 15 (err=1, 1-cycle latency) and the BUSY state is unreachable.

Structure
REQ-031 A shared package pipe_alu_pkg holds the CMD encodings as named constants, the flag bit indices and the state type.
REQ-032 One sub-module, pipe_alu_mul (shift-add multiplier with start/done), is instantiated only under PIPE_ALU_MUL_EN; all other ops are combinational inside pipe_alu, with registered results.

Verification
REQ-033 N=6, A=5, B=3, CMD=8 (SRL) -> one cycle later out_valid=1, Z=0, zero=1, err=0.
REQ-034 N=6, A=31, B=1, CMD=0 (ADD) -> Z=32 (6'b100000), neg=1, ovf=1, carry=0.
REQ-035 N=6, A=9, B=9, CMD=14 with PIPE_ALU_MUL_EN -> out_valid 7 cycles after accept, Z=17, carry=1; in_ready=0 throughout BUSY.
REQ-036 out_ready held low for 5 cycles after a result -> Z and flags stable, in_valid offers not accepted; out_ready=1 -> IDLE on the next cycle.
REQ-037 rst_n pulsed low mid-MUL -> all outputs at reset values immediately; no out_valid after rst_n is released.
REQ-038 CMD=15, and CMD=14 with PIPE_ALU_MUL_EN undefined -> err=1, Z=0, 1-cycle latency.
